// File: rtl/xbar_cfg_pkg.sv
// ----------------------------------------------------------------------------
// xbar_cfg_pkg
// Shared definitions for the LUT-tile crossbar configuration loader:
//   - crossbar geometry (input count, output count, select field width,
//     total configuration width)
//   - loader FSM state encoding
//   - field offset helper mapping an output index to its bit position
// ----------------------------------------------------------------------------
package xbar_cfg_pkg;

  localparam int unsigned NUM_INS  = 24;
  localparam int unsigned NUM_OUTS = 30;
  localparam int unsigned SEL_BITS = 5;
  localparam int unsigned CFG_BITS = NUM_OUTS * SEL_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  // Bit position of the select field that belongs to crossbar output idx.
  function automatic int unsigned field_offset(input int unsigned idx,
                                               input int unsigned sel_bits);
    return idx * sel_bits;
  endfunction

endpackage : xbar_cfg_pkg

// File: rtl/xbar_cfg_loader.sv
// ----------------------------------------------------------------------------
// xbar_cfg_loader
// Streams one mux select per valid/ready beat into a shadow register and,
// once every crossbar output has a select, commits the whole configuration
// to the active register in a single cycle. The crossbar only ever sees a
// complete configuration; a sequence that carried an out-of-range select
// finishes without committing.
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   asynchronous, active-high reset
//   io_start       in   begin (or restart) a load sequence
//   io_cfg_valid   in   select beat valid
//   io_cfg_ready   out  beat accepted (LOAD only)
//   io_cfg_sel     in   select value for the current output index
//   io_busy        out  loader in LOAD or COMMIT
//   io_done        out  one-cycle pulse when a sequence finishes
//   io_err         out  sticky out-of-range flag for the current/last sequence
//   io_mux_configs out  active configuration, field i = select of output i
// ----------------------------------------------------------------------------
module xbar_cfg_loader #(
  parameter int unsigned NUM_INS  = xbar_cfg_pkg::NUM_INS,
  parameter int unsigned NUM_OUTS = xbar_cfg_pkg::NUM_OUTS,
  parameter int unsigned SEL_BITS = xbar_cfg_pkg::SEL_BITS,
  parameter int unsigned CFG_BITS = NUM_OUTS * SEL_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_start,
  input  logic                io_cfg_valid,
  output logic                io_cfg_ready,
  input  logic [SEL_BITS-1:0] io_cfg_sel,
  output logic                io_busy,
  output logic                io_done,
  output logic                io_err,
  output logic [CFG_BITS-1:0] io_mux_configs
);

  import xbar_cfg_pkg::*;

  localparam int unsigned           IDX_W       = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_OUTS - 1);
  // One extra bit so NUM_INS == 2**SEL_BITS still compares correctly.
  localparam logic [SEL_BITS:0]     NUM_INS_EXT = (SEL_BITS + 1)'(NUM_INS);

  cfg_state_t          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CFG_BITS-1:0] shadow_q;
  logic [CFG_BITS-1:0] active_q;
  logic                done_q;
  logic                err_q;

  logic                handshake;
  logic                sel_ok;
  logic [SEL_BITS-1:0] sel_field_d;

  // Moore decodes straight from state.
  assign io_cfg_ready = (state_q == LOAD);
  assign io_busy      = (state_q != IDLE);

  assign handshake   = io_cfg_valid & io_cfg_ready;
  assign sel_ok      = ({1'b0, io_cfg_sel} < NUM_INS_EXT);
  // Out-of-range selects park the field on input 0.
  assign sel_field_d = sel_ok ? io_cfg_sel : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: shadow and active are reset too; the crossbar must come up
      // with every output on input 0, not on whatever the flops power up to.
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (io_start) begin
            state_q <= LOAD;
            idx_q   <= '0;
            err_q   <= 1'b0;
          end
        end

        LOAD: begin
          if (io_start) begin
            // Restart wins over a beat presented in the same cycle.
            idx_q <= '0;
            err_q <= 1'b0;
          end else if (handshake) begin
            shadow_q[field_offset(32'(idx_q), SEL_BITS) +: SEL_BITS] <= sel_field_d;
            if (!sel_ok) begin
              err_q <= 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              // idx stays on the last field; the next start clears it.
              state_q <= COMMIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end

        COMMIT: begin
          // err_q already includes the last beat, which landed one edge ago.
          if (!err_q) begin
            active_q <= shadow_q;
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_done        = done_q;
  assign io_err         = err_q;
  assign io_mux_configs = active_q;

endmodule : xbar_cfg_loader

// File: tb/tb_xbar_cfg_loader.sv
// ----------------------------------------------------------------------------
// tb_xbar_cfg_loader
// Directed bench for xbar_cfg_loader with a behavioural crossbar downstream
// of io_mux_configs for end-to-end routing checks. Inputs are driven and
// outputs sampled on the falling edge, half a cycle away from the active edge.
// ----------------------------------------------------------------------------
module tb_xbar_cfg_loader;

  import xbar_cfg_pkg::*;

  typedef logic [CFG_BITS-1:0] chk_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                io_start;
  logic                io_cfg_valid;
  logic                io_cfg_ready;
  logic [SEL_BITS-1:0] io_cfg_sel;
  logic                io_busy;
  logic                io_done;
  logic                io_err;
  logic [CFG_BITS-1:0] io_mux_configs;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus vector for one load and crossbar input data.
  logic [SEL_BITS-1:0] vec     [NUM_OUTS];
  logic [7:0]          xbar_in [NUM_INS];

  // Observations captured by run_load.
  int   beats_sent;
  int   loop_done;
  int   busy_low;
  logic commit_busy, commit_done;
  logic done_now, err_now, ready_after, done_after;
  chk_t cfg_now;
  chk_t prev_cfg;

  xbar_cfg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .io_start       (io_start),
    .io_cfg_valid   (io_cfg_valid),
    .io_cfg_ready   (io_cfg_ready),
    .io_cfg_sel     (io_cfg_sel),
    .io_busy        (io_busy),
    .io_done        (io_done),
    .io_err         (io_err),
    .io_mux_configs (io_mux_configs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input chk_t got, input chk_t exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Configuration a successful commit of vec must produce.
  function automatic chk_t expect_cfg();
    chk_t c = '0;
    for (int i = 0; i < NUM_OUTS; i++) begin
      c[i*SEL_BITS +: SEL_BITS] = (int'(vec[i]) < NUM_INS) ? vec[i] : '0;
    end
    return c;
  endfunction

  // Behavioural crossbar: output o carries the input its field selects.
  function automatic logic [7:0] route(input chk_t cfg, input int o);
    logic [SEL_BITS-1:0] s;
    s = cfg[o*SEL_BITS +: SEL_BITS];
    return xbar_in[s];
  endfunction

  // Optionally start, send all NUM_OUTS beats of vec (with a fixed stall
  // pattern if requested), then capture the COMMIT and done cycles.
  task automatic run_load(input bit stall, input bit do_start);
    int cyc;
    cyc        = 0;
    beats_sent = 0;
    loop_done  = 0;
    busy_low   = 0;
    if (do_start) begin
      @(negedge clk);
      io_start     = 1'b1;
      io_cfg_valid = 1'b0;
      @(negedge clk);
      io_start = 1'b0;
    end
    while (beats_sent < NUM_OUTS && cyc < 1000) begin
      io_cfg_valid = !(stall && (cyc % 3 == 2));
      io_cfg_sel   = vec[beats_sent];
      @(negedge clk);
      cyc++;
      if (!io_busy) busy_low++;
      if (io_done)  loop_done++;
      if (io_cfg_valid) beats_sent++;
    end
    io_cfg_valid = 1'b0;
    commit_busy  = io_busy;
    commit_done  = io_done;
    @(negedge clk);
    done_now    = io_done;
    err_now     = io_err;
    cfg_now     = io_mux_configs;
    ready_after = io_cfg_ready;
    @(negedge clk);
    done_after = io_done;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < NUM_INS; j++) xbar_in[j] = 8'(j * 9 + 17);

    reset        = 1'b1;
    io_start     = 1'b0;
    io_cfg_valid = 1'b0;
    io_cfg_sel   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst ready", chk_t'(io_cfg_ready), chk_t'(0));
    check("rst busy",  chk_t'(io_busy),      chk_t'(0));
    check("rst done",  chk_t'(io_done),      chk_t'(0));
    check("rst err",   chk_t'(io_err),       chk_t'(0));
    check("rst cfg",   io_mux_configs,       chk_t'(0));

    // Full back-to-back load, sel = i mod 24
    for (int i = 0; i < NUM_OUTS; i++) vec[i] = SEL_BITS'(i % NUM_INS);
    run_load(1'b0, 1'b1);
    check("full busy in load",   chk_t'(busy_low),    chk_t'(0));
    check("full no early done",  chk_t'(loop_done),   chk_t'(0));
    check("full commit busy",    chk_t'(commit_busy), chk_t'(1));
    check("full commit no done", chk_t'(commit_done), chk_t'(0));
    check("full done pulse",     chk_t'(done_now),    chk_t'(1));
    check("full done one cycle", chk_t'(done_after),  chk_t'(0));
    check("full ready idle",     chk_t'(ready_after), chk_t'(0));
    check("full err",            chk_t'(err_now),     chk_t'(0));
    check("full cfg",            cfg_now,             expect_cfg());
    for (int o = 0; o < NUM_OUTS; o++) begin
      check($sformatf("route out%0d", o), chk_t'(route(cfg_now, o)),
            chk_t'(xbar_in[o % NUM_INS]));
    end
    prev_cfg = expect_cfg();

    // Stalled load, same data
    run_load(1'b1, 1'b1);
    check("stall busy in load", chk_t'(busy_low), chk_t'(0));
    check("stall done once",    chk_t'(loop_done + int'(commit_done) + int'(done_now)
                                       + int'(done_after)), chk_t'(1));
    check("stall done pulse",   chk_t'(done_now), chk_t'(1));
    check("stall cfg",          cfg_now,          prev_cfg);

    // Out-of-range select on beat 7: no commit, err sticky
    for (int i = 0; i < NUM_OUTS; i++) vec[i] = SEL_BITS'((i + 5) % NUM_INS);
    vec[7] = SEL_BITS'(25);
    run_load(1'b0, 1'b1);
    check("oor done",       chk_t'(done_now), chk_t'(1));
    check("oor err",        chk_t'(err_now),  chk_t'(1));
    check("oor cfg kept",   cfg_now,          prev_cfg);
    check("oor err sticky", chk_t'(io_err),   chk_t'(1));

    // Restart mid-load with a bad beat in the same cycle as start
    @(negedge clk);
    io_start     = 1'b1;
    io_cfg_valid = 1'b0;
    @(negedge clk);
    io_start = 1'b0;
    check("start clears err", chk_t'(io_err), chk_t'(0));
    for (int i = 0; i < 12; i++) begin
      io_cfg_valid = 1'b1;
      io_cfg_sel   = (i == 5) ? SEL_BITS'(30) : SEL_BITS'(9);
      @(negedge clk);
    end
    check("pre-restart err", chk_t'(io_err), chk_t'(1));
    io_start     = 1'b1;
    io_cfg_valid = 1'b1;
    io_cfg_sel   = SEL_BITS'(31);
    @(negedge clk);
    io_start = 1'b0;
    check("restart err cleared", chk_t'(io_err),  chk_t'(0));
    check("restart busy",        chk_t'(io_busy), chk_t'(1));
    for (int i = 0; i < NUM_OUTS; i++) vec[i] = SEL_BITS'(3);
    run_load(1'b0, 1'b0);
    check("restart done", chk_t'(done_now), chk_t'(1));
    check("restart err",  chk_t'(err_now),  chk_t'(0));
    check("restart cfg",  cfg_now,          expect_cfg());

    // Asynchronous reset mid-load, between clock edges
    for (int i = 0; i < NUM_OUTS; i++) vec[i] = SEL_BITS'(i % NUM_INS);
    vec[4] = SEL_BITS'(28);
    @(negedge clk);
    io_start = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      io_cfg_valid = 1'b1;
      io_cfg_sel   = vec[i];
      @(negedge clk);
    end
    io_cfg_valid = 1'b0;
    check("pre-reset err", chk_t'(io_err), chk_t'(1));
    #2;
    reset = 1'b1;
    #1;
    check("async rst ready", chk_t'(io_cfg_ready), chk_t'(0));
    check("async rst busy",  chk_t'(io_busy),      chk_t'(0));
    check("async rst done",  chk_t'(io_done),      chk_t'(0));
    check("async rst err",   chk_t'(io_err),       chk_t'(0));
    check("async rst cfg",   io_mux_configs,       chk_t'(0));
    @(negedge clk);
    reset = 1'b0;

    // Full load after the reset commits cleanly
    vec[4] = SEL_BITS'(4);
    run_load(1'b0, 1'b1);
    check("post-rst done", chk_t'(done_now), chk_t'(1));
    check("post-rst err",  chk_t'(err_now),  chk_t'(0));
    check("post-rst cfg",  cfg_now,          expect_cfg());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_xbar_cfg_loader
